// File: rtl/fft_twiddle_butterfly_core.sv
// fft_twiddle_butterfly_core
//   Arithmetic core of a 16-point radix-2^2 SDF FFT. It contains:
//     - BF1: stage-A butterfly (add/sub or bypass)
//     - BF2: stage-B butterfly with an optional -j rotation of X2
//     - a registered 16-entry W16^k twiddle ROM (Q2.14, {re,im})
//   Both butterflies are combinational and wrap modulo 2^WIDTH.
//   The ROM has a 1-cycle read latency. Reset clears only the ROM register.
// Ports:
//   clk, i_reset                 clock, async active-high reset
//   bf1_x_*, bf1_x2_*            BF1 operands (delay line, new sample)
//   bf1_control                  1 = butterfly, 0 = bypass
//   bf1_z_*, bf1_z2_*            BF1 forward / delay-line outputs
//   bf2_x_*, bf2_x2_*            BF2 operands
//   bf2_control, bf2_conjugate   butterfly enable, -j rotation of X2
//   bf2_z_*, bf2_z2_*            BF2 forward / delay-line outputs
//   twi_addr, twiddle            ROM index k, registered W16^k

// Shared butterfly datapath: z = x + y, z2 = x - y when control is set.
// Otherwise z = x and z2 = pass (the unrotated new sample).
module fft_bf_unit #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x_re,
  input  logic [WIDTH-1:0] x_im,
  input  logic [WIDTH-1:0] y_re,
  input  logic [WIDTH-1:0] y_im,
  input  logic [WIDTH-1:0] pass_re,
  input  logic [WIDTH-1:0] pass_im,
  input  logic             control,
  output logic [WIDTH-1:0] z_re,
  output logic [WIDTH-1:0] z_im,
  output logic [WIDTH-1:0] z2_re,
  output logic [WIDTH-1:0] z2_im
);
  assign z_re  = control ? x_re + y_re : x_re;
  assign z_im  = control ? x_im + y_im : x_im;
  assign z2_re = control ? x_re - y_re : pass_re;
  assign z2_im = control ? x_im - y_im : pass_im;
endmodule

module fft_twiddle_butterfly_core #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] bf1_x_re,
  input  logic [WIDTH-1:0] bf1_x_im,
  input  logic [WIDTH-1:0] bf1_x2_re,
  input  logic [WIDTH-1:0] bf1_x2_im,
  input  logic             bf1_control,
  output logic [WIDTH-1:0] bf1_z_re,
  output logic [WIDTH-1:0] bf1_z_im,
  output logic [WIDTH-1:0] bf1_z2_re,
  output logic [WIDTH-1:0] bf1_z2_im,
  input  logic [WIDTH-1:0] bf2_x_re,
  input  logic [WIDTH-1:0] bf2_x_im,
  input  logic [WIDTH-1:0] bf2_x2_re,
  input  logic [WIDTH-1:0] bf2_x2_im,
  input  logic             bf2_control,
  input  logic             bf2_conjugate,
  output logic [WIDTH-1:0] bf2_z_re,
  output logic [WIDTH-1:0] bf2_z_im,
  output logic [WIDTH-1:0] bf2_z2_re,
  output logic [WIDTH-1:0] bf2_z2_im,
  input  logic [3:0]       twi_addr,
  output logic [31:0]      twiddle
);

  // BF1
  fft_bf_unit #(.WIDTH(WIDTH)) u_bf1 (
    .x_re(bf1_x_re), .x_im(bf1_x_im),
    .y_re(bf1_x2_re), .y_im(bf1_x2_im),
    .pass_re(bf1_x2_re), .pass_im(bf1_x2_im),
    .control(bf1_control),
    .z_re(bf1_z_re), .z_im(bf1_z_im),
    .z2_re(bf1_z2_re), .z2_im(bf1_z2_im)
  );

  // BF2: -j*(a + jb) = b - ja. Negation wraps, so -(-2^(W-1)) stays put.
  logic [WIDTH-1:0] bf2_y_re, bf2_y_im;
  assign bf2_y_re = bf2_conjugate ? bf2_x2_im : bf2_x2_re;
  assign bf2_y_im = bf2_conjugate ? WIDTH'(0) - bf2_x2_re : bf2_x2_im;

  // Bypass forwards the raw X2, not the rotated Y.
  fft_bf_unit #(.WIDTH(WIDTH)) u_bf2 (
    .x_re(bf2_x_re), .x_im(bf2_x_im),
    .y_re(bf2_y_re), .y_im(bf2_y_im),
    .pass_re(bf2_x2_re), .pass_im(bf2_x2_im),
    .control(bf2_control),
    .z_re(bf2_z_re), .z_im(bf2_z_im),
    .z2_re(bf2_z2_re), .z2_im(bf2_z2_im)
  );

  // Twiddle ROM: W16^k = cos(2pi k/16) - j sin(2pi k/16), Q2.14, {re,im}.
  // All 16 entries are populated, although the pipeline only uses k <= 9.
  logic [31:0] twiddle_d, twiddle_q;

  always_comb begin
    twiddle_d = 32'h0000_0000;
    case (twi_addr)
      4'd0:  twiddle_d = 32'h4000_0000;
      4'd1:  twiddle_d = 32'h3B21_E782;
      4'd2:  twiddle_d = 32'h2D41_D2BF;
      4'd3:  twiddle_d = 32'h187E_C4DF;
      4'd4:  twiddle_d = 32'h0000_C000;
      4'd5:  twiddle_d = 32'hE782_C4DF;
      4'd6:  twiddle_d = 32'hD2BF_D2BF;
      4'd7:  twiddle_d = 32'hC4DF_E782;
      4'd8:  twiddle_d = 32'hC000_0000;
      4'd9:  twiddle_d = 32'hC4DF_187E;
      4'd10: twiddle_d = 32'hD2BF_2D41;
      4'd11: twiddle_d = 32'hE782_3B21;
      4'd12: twiddle_d = 32'h0000_4000;
      4'd13: twiddle_d = 32'h187E_3B21;
      4'd14: twiddle_d = 32'h2D41_2D41;
      4'd15: twiddle_d = 32'h3B21_187E;
      default: twiddle_d = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) twiddle_q <= 32'h0000_0000;
    else         twiddle_q <= twiddle_d;
  end

  assign twiddle = twiddle_q;

endmodule

// File: tb/tb_fft_twiddle_butterfly_core.sv
module tb_fft_twiddle_butterfly_core;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         i_reset;
  logic [W-1:0] bf1_x_re, bf1_x_im, bf1_x2_re, bf1_x2_im;
  logic         bf1_control;
  logic [W-1:0] bf1_z_re, bf1_z_im, bf1_z2_re, bf1_z2_im;
  logic [W-1:0] bf2_x_re, bf2_x_im, bf2_x2_re, bf2_x2_im;
  logic         bf2_control, bf2_conjugate;
  logic [W-1:0] bf2_z_re, bf2_z_im, bf2_z2_re, bf2_z2_im;
  logic [3:0]   twi_addr;
  logic [31:0]  twiddle;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  fft_twiddle_butterfly_core #(.WIDTH(W)) dut (
    .clk(clk), .i_reset(i_reset),
    .bf1_x_re(bf1_x_re), .bf1_x_im(bf1_x_im),
    .bf1_x2_re(bf1_x2_re), .bf1_x2_im(bf1_x2_im),
    .bf1_control(bf1_control),
    .bf1_z_re(bf1_z_re), .bf1_z_im(bf1_z_im),
    .bf1_z2_re(bf1_z2_re), .bf1_z2_im(bf1_z2_im),
    .bf2_x_re(bf2_x_re), .bf2_x_im(bf2_x_im),
    .bf2_x2_re(bf2_x2_re), .bf2_x2_im(bf2_x2_im),
    .bf2_control(bf2_control), .bf2_conjugate(bf2_conjugate),
    .bf2_z_re(bf2_z_re), .bf2_z_im(bf2_z_im),
    .bf2_z2_re(bf2_z2_re), .bf2_z2_im(bf2_z2_im),
    .twi_addr(twi_addr), .twiddle(twiddle)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Hand-written ROM table, from the cos/-sin values scaled by 16384.
  logic [31:0] rom_exp [16] = '{
    32'h4000_0000, 32'h3B21_E782, 32'h2D41_D2BF, 32'h187E_C4DF,
    32'h0000_C000, 32'hE782_C4DF, 32'hD2BF_D2BF, 32'hC4DF_E782,
    32'hC000_0000, 32'hC4DF_187E, 32'hD2BF_2D41, 32'hE782_3B21,
    32'h0000_4000, 32'h187E_3B21, 32'h2D41_2D41, 32'h3B21_187E};

  function automatic logic [63:0] bf1_out();
    return {bf1_z_re, bf1_z_im, bf1_z2_re, bf1_z2_im};
  endfunction
  function automatic logic [63:0] bf2_out();
    return {bf2_z_re, bf2_z_im, bf2_z2_re, bf2_z2_im};
  endfunction
  function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
    return {W'(a), W'(b), W'(c), W'(d)};
  endfunction

  initial begin
    logic [W-1:0] xr, xi, x2r, x2i, yr, yi;
    logic [63:0]  m1, m2;

    i_reset = 1'b1; twi_addr = 4'd0;
    bf1_x_re = '0; bf1_x_im = '0; bf1_x2_re = '0; bf1_x2_im = '0; bf1_control = 1'b0;
    bf2_x_re = '0; bf2_x_im = '0; bf2_x2_re = '0; bf2_x2_im = '0;
    bf2_control = 1'b0; bf2_conjugate = 1'b0;
    #1;
    chk("reset_twiddle", {32'h0, twiddle}, 64'h0);
    @(posedge clk); #1;
    chk("reset_hold", {32'h0, twiddle}, 64'h0);

    // BF1 directed
    bf1_x_re = W'(100); bf1_x_im = W'(-50); bf1_x2_re = W'(30); bf1_x2_im = W'(20);
    bf1_control = 1'b0; #1;
    chk("bf1_bypass", bf1_out(), pk(100, -50, 30, 20));
    bf1_control = 1'b1; #1;
    chk("bf1_add", bf1_out(), pk(130, -30, 70, -70));
    bf1_x_re = W'(32767); bf1_x_im = '0; bf1_x2_re = W'(1); bf1_x2_im = '0; #1;
    chk("bf1_wrap", bf1_out(), pk(-32768, 0, 32766, 0));

    // BF2 directed
    bf2_x_re = W'(10); bf2_x_im = W'(20); bf2_x2_re = W'(3); bf2_x2_im = W'(4);
    bf2_control = 1'b1; bf2_conjugate = 1'b0; #1;
    chk("bf2_noconj", bf2_out(), pk(13, 24, 7, 16));
    bf2_conjugate = 1'b1; #1;
    chk("bf2_conj", bf2_out(), pk(14, 17, 6, 23));
    bf2_control = 1'b0; bf2_conjugate = 1'b0; #1;
    chk("bf2_byp_c0", bf2_out(), pk(10, 20, 3, 4));
    bf2_conjugate = 1'b1; #1;
    chk("bf2_byp_c1", bf2_out(), pk(10, 20, 3, 4));
    // -(-32768) wraps to -32768
    bf2_x_re = '0; bf2_x_im = '0; bf2_x2_re = W'(-32768); bf2_x2_im = W'(5);
    bf2_control = 1'b1; #1;
    chk("bf2_negmin", bf2_out(), pk(5, -32768, -5, -32768));

    // Reset does not touch butterflies
    chk("bf1_in_reset", bf1_out(), pk(-32768, 0, 32766, 0));

    // ROM sweep, one address per edge
    @(negedge clk); i_reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      twi_addr = 4'(k);
      @(posedge clk); #1;
      chk($sformatf("rom_k%0d", k), {32'h0, twiddle}, {32'h0, rom_exp[k]});
    end

    // Async reset mid-cycle
    twi_addr = 4'd2;
    @(posedge clk); #1;
    chk("pre_rst_k2", {32'h0, twiddle}, 64'h2D41_D2BF);
    #2 i_reset = 1'b1; #1;
    chk("async_rst", {32'h0, twiddle}, 64'h0);
    twi_addr = 4'd3;
    @(posedge clk); #1;
    chk("rst_held", {32'h0, twiddle}, 64'h0);
    @(negedge clk); i_reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_release_k3", {32'h0, twiddle}, 64'h187E_C4DF);

    // Random regression against a signed-int model truncated to W bits
    for (int n = 0; n < 10000; n++) begin
      xr = W'($urandom); xi = W'($urandom); x2r = W'($urandom); x2i = W'($urandom);
      bf1_x_re = xr; bf1_x_im = xi; bf1_x2_re = x2r; bf1_x2_im = x2i;
      bf1_control = 1'($urandom);
      bf2_x_re = x2i; bf2_x_im = x2r; bf2_x2_re = xi; bf2_x2_im = xr;
      bf2_control = 1'($urandom); bf2_conjugate = 1'($urandom);
      #1;
      if (bf1_control)
        m1 = pk(int'(xr) + int'(x2r), int'(xi) + int'(x2i),
                int'(xr) - int'(x2r), int'(xi) - int'(x2i));
      else
        m1 = pk(int'(xr), int'(xi), int'(x2r), int'(x2i));
      if (bf2_conjugate) begin yr = xr; yi = W'(-int'(xi)); end
      else               begin yr = xi; yi = xr; end
      if (bf2_control)
        m2 = pk(int'(x2i) + int'(yr), int'(x2r) + int'(yi),
                int'(x2i) - int'(yr), int'(x2r) - int'(yi));
      else
        m2 = pk(int'(x2i), int'(x2r), int'(xi), int'(xr));
      chk("rand_bf1", bf1_out(), m1);
      chk("rand_bf2", bf2_out(), m2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/fft_twiddle_butterfly_core.md
# fft_twiddle_butterfly_core

Arithmetic core of the 16-point radix-2² single-path delay-feedback FFT. It bundles three sub-functions: the stage-A butterfly (BF1), the stage-B butterfly (BF2) with the trivial −j rotation, and the registered 16-entry twiddle ROM that feeds the non-trivial complex multiplier. The surrounding pipeline supplies the control sequencing, feedback delay lines, multiplier, rounding and saturation.

## Interface
Parameters:
- WIDTH, 16, two's-complement width of every butterfly operand component.

Ports:
- clk  in  1  single clock; ROM output register updates on the rising edge.
- i_reset  in  1  asynchronous, active-high reset; clears the ROM output register only.
- bf1_x_re, bf1_x_im  in  WIDTH  BF1 operand X, from the stage-A delay line.
- bf1_x2_re, bf1_x2_im  in  WIDTH  BF1 operand X2, the new sample.
- bf1_control  in  1  1 = butterfly, 0 = bypass.
- bf1_z_re, bf1_z_im  out  WIDTH  BF1 forward output.
- bf1_z2_re, bf1_z2_im  out  WIDTH  BF1 output to the delay line.
- bf2_x_re, bf2_x_im  in  WIDTH  BF2 operand X, from the stage-B delay line.
- bf2_x2_re, bf2_x2_im  in  WIDTH  BF2 operand X2.
- bf2_control  in  1  1 = butterfly, 0 = bypass.
- bf2_conjugate  in  1  1 = rotate X2 by −j before the butterfly.
- bf2_z_re, bf2_z_im  out  WIDTH  BF2 forward output.
- bf2_z2_re, bf2_z2_im  out  WIDTH  BF2 output to the delay line.
- twi_addr  in  4  twiddle index k.
- twiddle  out  32  {re[31:16], im[15:0]} of W16^k, Q2.14.

## Operation
- Both butterflies are purely combinational. All sums are taken modulo 2^WIDTH (wrap-around, no growth, no saturation).
- BF1, control=1: z = X + X2, z2 = X − X2, component-wise.
- BF1, control=0: z = X, z2 = X2. X is passed forward and the new sample enters the delay.
- BF2: Y = X2 when bf2_conjugate=0; Y = (X2.im, −X2.re), i.e. −j·X2, when bf2_conjugate=1.
- BF2, control=1: z = X + Y, z2 = X − Y.
- BF2, control=0: z = X, z2 = X2. bf2_conjugate is ignored.
- −X2.re is computed as 0 − X2.re mod 2^WIDTH, so −(−32768) = −32768.
- ROM content: W16^k = cos(2πk/16) − j·sin(2πk/16), scaled by 16384 and rounded to nearest. Real part is in the upper 16 bits, imaginary part in the lower 16 bits.
- ROM contents (re, im) for k = 0..15:
  - k0–3: (16384, 0), (15137, −6270), (11585, −11585), (6270, −15137)
  - k4–7: (0, −16384), (−6270, −15137), (−11585, −11585), (−15137, −6270)
  - k8–11: (−16384, 0), (−15137, 6270), (−11585, 11585), (−6270, 15137)
  - k12–15: (0, 16384), (6270, 15137), (11585, 11585), (15137, 6270)
- The pipeline drives twi_addr = n·k with n, k ∈ 0..3 (maximum 9). All 16 entries are still populated.

## Timing
- Butterfly outputs follow inputs within the same cycle; latency 0.
- ROM: synchronous read with 1-cycle latency. twiddle at edge t+1 reflects twi_addr sampled at edge t.
- A new address every cycle is supported. There are no enable or stall inputs.
- Reset state: twiddle = 32'h0000_0000 immediately on i_reset assertion, independent of clk. It stays 0 while i_reset is high.
- Release: the first rising edge after deassertion loads the ROM entry for the current twi_addr.
- Reset asserted mid-stream forces twiddle to 0 immediately. Butterfly outputs are unaffected by reset.

## Test plan
- BF1 bypass/add: X=(100,−50), X2=(30,20). control=0 → z=(100,−50), z2=(30,20). control=1 → z=(130,−30), z2=(70,−70).
- BF1 wrap: X=(32767,0), X2=(1,0), control=1 → z.re=−32768, z2.re=32766.
- BF2 −j rotation: X=(10,20), X2=(3,4).
  - conj=0, control=1 → z=(13,24), z2=(7,16).
  - conj=1, control=1 → z=(14,17), z2=(6,23).
  - control=0 with either conj → z=(10,20), z2=(3,4).
- ROM sweep: apply addresses 0..15 on successive edges. Each twiddle appears one cycle later: k0=32'h4000_0000, k1=32'h3B21_E782, k2=32'h2D41_D2BF, k4=32'h0000_C000, k8=32'hC000_0000, k9=32'hC4DF_187E.
- Async reset: assert i_reset between edges while twiddle=k2 → twiddle=0 without a clock edge. Release with addr=3 → next edge gives 32'h187E_C4DF.
- Random regression: 10k random BF1/BF2 operand and control combinations, checked against a modulo-2^16 golden model.
